median_window_gen5: RTL and testbench



---
 rtl/median_window_gen5_pkg.sv | 21 ++
 rtl/mwg_line_buffer.sv | 38 +++
 rtl/median_window_gen5.sv | 192 +++++++++++++++++++
 tb/tb_median_window_gen5.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/median_window_gen5_pkg.sv
// Shared constants, FSM state type and window index helper for the 5x5 median window generator.
// No logic of its own; imported by median_window_gen5 and mwg_line_buffer.
package median_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int WIN            = 5;
    localparam int WIN_PIX        = 25;
    localparam int CENTER_IDX     = 12;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        DONE
    } state_t;

    // Flat win_pix slice number for window row/column (row 0 = oldest line, col 0 = leftmost).
    function automatic int pix_idx(input int row, input int col);
        return row * WIN + col;
    endfunction

endpackage

// File: rtl/mwg_line_buffer.sv
// One video line of storage: combinational read of the addressed entry, write on the same edge (read-before-write).
// Latency 0 for reads, 1 for writes; no flow control. RECURSIVE_WB_EN adds a second write port for median write-back.
module mwg_line_buffer
    import median_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef RECURSIVE_WB_EN
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
`endif
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Contents are deliberately not reset; every entry is rewritten before a window uses it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
`ifdef RECURSIVE_WB_EN
        if (wb_en) begin
            mem[wb_addr] <= wb_data;
        end
`endif
    end

endmodule

// File: rtl/median_window_gen5.sv
// Streaming 5x5 window generator over raster pixels; emits each fully populated window with its centre coordinate.
// Latency 1 cycle from accepted pixel to win_valid; always ready, no backpressure. Macro RECURSIVE_WB_EN adds median write-back.
module median_window_gen5
    import median_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = DATA_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [DATA_W-1:0]         in_data,
`ifdef RECURSIVE_WB_EN
    input  logic                      med_valid,
    input  logic [DATA_W-1:0]         med_data,
`endif
    output logic                      win_valid,
    output logic [WIN_PIX*DATA_W-1:0] win_pix,
    output logic [15:0]               win_cx,
    output logic [15:0]               win_cy,
    output logic                      frame_err
);

    localparam int AW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int NLB  = WIN - 1;
    localparam int CTR  = WIN / 2;

    state_t state, state_nxt;
    logic [15:0] x, y, x_nxt, y_nxt, pos_x, pos_y;
    logic        accept, abort, drop_err, emit;

    logic [DATA_W-1:0] lb_rd   [NLB];
    logic [DATA_W-1:0] lb_wr   [NLB];
    logic [DATA_W-1:0] new_col [WIN];
    logic [DATA_W-1:0] sr_q    [WIN][WIN];
    logic [DATA_W-1:0] sr_d    [WIN][WIN];
    logic [WIN_PIX*DATA_W-1:0] sr_flat;

`ifdef RECURSIVE_WB_EN
    logic wb_en;
    assign wb_en = med_valid & win_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_nxt;
        end
    end

    // An in_sof pixel is always position (0,0), whatever the counters hold.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        abort     = 1'b0;
        drop_err  = 1'b0;
        x_nxt     = x;
        y_nxt     = y;
        pos_x     = in_sof ? 16'd0 : x;
        pos_y     = in_sof ? 16'd0 : y;
        case (state)
            WAIT_SOF: accept = in_valid & in_sof;
            ACTIVE: begin
                accept = in_valid;
                abort  = in_valid & in_sof;
            end
            DONE: begin
                accept   = in_valid & in_sof;
                drop_err = in_valid & ~in_sof;
            end
            default: state_nxt = WAIT_SOF;
        endcase
        if (accept) begin
            state_nxt = ACTIVE;
            if (pos_x == 16'(IMG_WIDTH - 1)) begin
                x_nxt = 16'd0;
                y_nxt = pos_y + 16'd1;
                if (pos_y == 16'(IMG_HEIGHT - 1)) begin
                    y_nxt     = 16'd0;
                    state_nxt = DONE;
                end
            end else begin
                x_nxt = pos_x + 16'd1;
                y_nxt = pos_y;
            end
        end
        emit = accept && (pos_x >= 16'd4) && (pos_y >= 16'd4);
    end

    // Line buffers are chained: entry k holds line y-k at columns already visited this line.
    assign lb_wr[0] = in_data;
    for (genvar k = 1; k < NLB; k++) begin : g_chain
        assign lb_wr[k] = lb_rd[k-1];
    end

    for (genvar k = 0; k < NLB; k++) begin : g_lb
        mwg_line_buffer #(
            .DEPTH  (IMG_WIDTH),
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_lb (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (pos_x[AW-1:0]),
            .wr_data (lb_wr[k]),
`ifdef RECURSIVE_WB_EN
            .wb_en   (wb_en && (k == CTR)),
            .wb_addr (win_cx[AW-1:0]),
            .wb_data (med_data),
`endif
            .rd_data (lb_rd[k])
        );
    end

    for (genvar r = 0; r < NLB; r++) begin : g_col
        assign new_col[r] = lb_rd[NLB-1-r];
    end
    assign new_col[WIN-1] = in_data;

    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                sr_d[r][c] = sr_q[r][c];
            end
        end
        if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    sr_d[r][c] = abort ? '0 : sr_q[r][c+1];
                end
                sr_d[r][WIN-1] = new_col[r];
            end
        end
`ifdef RECURSIVE_WB_EN
        // The filtered centre follows the shift if a pixel is accepted in the same cycle.
        if (wb_en && !abort) begin
            if (accept) begin
                sr_d[CTR][CTR-1] = med_data;
            end else begin
                sr_d[CTR][CTR] = med_data;
            end
        end
`endif
    end

    always_comb begin
        sr_flat = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                sr_flat[pix_idx(r, c)*DATA_W +: DATA_W] = sr_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= 16'd0;
            y         <= 16'd0;
            win_valid <= 1'b0;
            win_pix   <= '0;
            win_cx    <= 16'd0;
            win_cy    <= 16'd0;
            frame_err <= 1'b0;
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    sr_q[r][c] <= '0;
                end
            end
        end else begin
            x         <= x_nxt;
            y         <= y_nxt;
            win_valid <= emit;
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    sr_q[r][c] <= sr_d[r][c];
                end
            end
            if (emit) begin
                win_pix <= sr_flat;
                win_cx  <= pos_x - 16'd2;
                win_cy  <= pos_y - 16'd2;
            end
            if (drop_err) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_median_window_gen5.sv
// Directed bench for median_window_gen5 on an 8x6 frame: ramp windows, idle gaps, abort, frame_err, reset, write-back.
module tb_median_window_gen5;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int NWIN = (W - 4) * (H - 4);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_sof;
    logic [DW-1:0]     in_data;
    logic              win_valid;
    logic [25*DW-1:0]  win_pix;
    logic [15:0]       win_cx;
    logic [15:0]       win_cy;
    logic              frame_err;
`ifdef RECURSIVE_WB_EN
    logic              med_valid;
    logic [DW-1:0]     med_data;
    int                seen_a;
    int                seen_b;
`endif

    int checks   = 0;
    int failures = 0;
    int win_cnt;
    int exp_idx;
    bit mon_on;
    bit wb_mode;
    bit last_drv;

    always #5 clk = ~clk;

    median_window_gen5 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
`ifdef RECURSIVE_WB_EN
        .med_valid (med_valid),
        .med_data  (med_data),
`endif
        .win_valid (win_valid),
        .win_pix   (win_pix),
        .win_cx    (win_cx),
        .win_cy    (win_cy),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ramp frame: pixel (x,y) carries y*W+x.
    function automatic logic [25*DW-1:0] ramp_win(input int cx, input int cy);
        logic [25*DW-1:0] v;
        v = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                v[(r*5+c)*DW +: DW] = 8'((cy - 2 + r) * W + (cx - 2 + c));
            end
        end
        return v;
    endfunction

    task automatic observe();
        int ecx;
        int ecy;
        if (win_valid) begin
            win_cnt++;
            check("win_after_accept", 256'(last_drv), 256'(1));
            if (mon_on) begin
                ecx = 2 + exp_idx % (W - 4);
                ecy = 2 + exp_idx / (W - 4);
                check("win_cx", 256'(win_cx), 256'(ecx));
                check("win_cy", 256'(win_cy), 256'(ecy));
                check("win_pix", 256'(win_pix), 256'(ramp_win(ecx, ecy)));
                exp_idx++;
            end
`ifdef RECURSIVE_WB_EN
            if (wb_mode && win_cx == 16'd3 && win_cy == 16'd2) begin
                seen_a++;
                check("wb_shifted_centre", 256'(win_pix[11*DW +: DW]), 256'(7));
            end
            if (wb_mode && win_cx == 16'd2 && win_cy == 16'd3) begin
                seen_b++;
                check("wb_line_buffer", 256'(win_pix[7*DW +: DW]), 256'(7));
            end
`endif
        end
`ifdef RECURSIVE_WB_EN
        med_valid = wb_mode & win_valid;
        med_data  = 8'd7;
`endif
    endtask

    task automatic send_px(input bit sof, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        last_drv = 1'b1;
        observe();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            last_drv = 1'b0;
            observe();
        end
    endtask

    task automatic run_frame(input int gap_max, input bit flat);
        for (int i = 0; i < W * H; i++) begin
            send_px(i == 0, flat ? 8'd100 : 8'(i));
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        mon_on = 1'b0; wb_mode = 1'b0; last_drv = 1'b0; win_cnt = 0; exp_idx = 0;
`ifdef RECURSIVE_WB_EN
        med_valid = 1'b0; med_data = '0; seen_a = 0; seen_b = 0;
`endif
        repeat (3) @(negedge clk);
        check("rst_win_valid", 256'(win_valid), 256'(0));
        check("rst_win_pix", 256'(win_pix), 256'(0));
        check("rst_win_cx", 256'(win_cx), 256'(0));
        check("rst_win_cy", 256'(win_cy), 256'(0));
        check("rst_frame_err", 256'(frame_err), 256'(0));
        rst = 1'b0;

        // Contiguous ramp frame with explicit first-window checks.
        mon_on = 1'b1; exp_idx = 0; win_cnt = 0;
        for (int i = 0; i < W * H; i++) begin
            send_px(i == 0, 8'(i));
            if (i == 35) check("no_win_before_4_4", 256'(win_valid), 256'(0));
            if (i == 36) begin
                check("first_latency", 256'(win_valid), 256'(1));
                check("first_cx", 256'(win_cx), 256'(2));
                check("first_cy", 256'(win_cy), 256'(2));
                check("first_pix12", 256'(win_pix[12*DW +: DW]), 256'(18));
                check("first_pix0", 256'(win_pix[0 +: DW]), 256'(0));
                check("first_pix24", 256'(win_pix[24*DW +: DW]), 256'(36));
            end
        end
        idle(3);
        check("count_contig", 256'(win_cnt), 256'(NWIN));

        // Same frame with random idle gaps.
        exp_idx = 0; win_cnt = 0;
        run_frame(5, 1'b0);
        idle(3);
        check("count_gaps", 256'(win_cnt), 256'(NWIN));

        // in_sof at (3,4) aborts; the restarted frame must begin again at centre (2,2).
        exp_idx = 0; win_cnt = 0;
        for (int i = 0; i < 4 * W + 3; i++) send_px(i == 0, 8'(i));
        check("abort_no_win", 256'(win_cnt), 256'(0));
        run_frame(0, 1'b0);
        idle(3);
        check("count_after_abort", 256'(win_cnt), 256'(NWIN));

        // Pixels after frame end without in_sof.
        mon_on = 1'b0; win_cnt = 0;
        send_px(1'b0, 8'h55);
        send_px(1'b0, 8'h56);
        check("err_set", 256'(frame_err), 256'(1));
        check("err_dropped", 256'(win_cnt), 256'(0));
        idle(4);
        check("err_sticky", 256'(frame_err), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("err_rst_clear", 256'(frame_err), 256'(0));

        // Reset mid-line while windows are being produced.
        win_cnt = 0;
        for (int i = 0; i < 4 * W + 6; i++) send_px(i == 0, 8'(i));
        check("pre_rst_windows", 256'(win_cnt), 256'(2));
        rst = 1'b1;
        send_px(1'b0, 8'(4 * W + 6));
        rst = 1'b0;
        check("midrst_win_valid", 256'(win_valid), 256'(0));
        check("midrst_cx", 256'(win_cx), 256'(0));
        for (int i = 0; i < 12; i++) send_px(1'b0, 8'(i));
        check("stray_ignored", 256'(win_cnt), 256'(2));
        check("stray_no_err", 256'(frame_err), 256'(0));
        mon_on = 1'b1; exp_idx = 0; win_cnt = 0;
        run_frame(0, 1'b0);
        idle(3);
        check("count_after_rst", 256'(win_cnt), 256'(NWIN));

`ifdef RECURSIVE_WB_EN
        mon_on = 1'b0; wb_mode = 1'b1;
        run_frame(0, 1'b1);
        idle(3);
        wb_mode = 1'b0;
        idle(1);
        check("wb_seen_3_2", 256'(seen_a), 256'(1));
        check("wb_seen_2_3", 256'(seen_b), 256'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
